// File: rtl/mbus_bcast_intercept_fifo_if.sv
// Bus bundle between the MBus node RX side, the layer RX side and the local
// capture-FIFO consumer of the broadcast interceptor.
`timescale 1ns/1ps
interface mbus_bcast_intercept_fifo_if #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned FUNC_WIDTH     = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_WIDTH = 8
);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  logic                      MASTER_EN;
  logic [ADDR_WIDTH-1:0]     NODE_RX_ADDR;
  logic [DATA_WIDTH-1:0]     NODE_RX_DATA;
  logic                      NODE_RX_REQ;
  logic                      NODE_RX_BROADCAST;
  logic                      NODE_RX_ACK;
  logic                      RX_REQ;
  logic                      RX_ACK;
  logic                      CAP_VALID;
  logic [FUNC_WIDTH-1:0]     CAP_CH;
  logic [DATA_WIDTH-1:0]     CAP_DATA;
  logic                      CAP_POP;
  logic [LVL_W-1:0]          CAP_LEVEL;
  logic [DROP_CNT_WIDTH-1:0] DROP_CNT;

  modport slave (
    input  MASTER_EN, NODE_RX_ADDR, NODE_RX_DATA, NODE_RX_REQ, NODE_RX_BROADCAST,
    input  RX_ACK, CAP_POP,
    output NODE_RX_ACK, RX_REQ, CAP_VALID, CAP_CH, CAP_DATA, CAP_LEVEL, DROP_CNT
  );

  modport master (
    output MASTER_EN, NODE_RX_ADDR, NODE_RX_DATA, NODE_RX_REQ, NODE_RX_BROADCAST,
    output RX_ACK, CAP_POP,
    input  NODE_RX_ACK, RX_REQ, CAP_VALID, CAP_CH, CAP_DATA, CAP_LEVEL, DROP_CNT
  );
endinterface

// File: rtl/mbus_bcast_intercept_fifo.sv
// Intercepts broadcasts on selected channels, hides them from the layer,
// auto-acks the node and queues the payloads for local consumers.
`timescale 1ns/1ps
module mbus_bcast_intercept_fifo #(
  parameter int unsigned                  ADDR_WIDTH     = 32,
  parameter int unsigned                  DATA_WIDTH     = 32,
  parameter int unsigned                  FUNC_WIDTH     = 4,
  parameter logic [(1<<FUNC_WIDTH)-1:0]   INTERCEPT_MASK = 16'h0001,
  parameter bit                           MASTER_ONLY    = 1'b1,
  parameter int unsigned                  FIFO_DEPTH     = 4,
  parameter int unsigned                  DROP_CNT_WIDTH = 8
) (
  input  logic                        CLK_EXT,
  input  logic                        RESETn_local,
  mbus_bcast_intercept_fifo_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE, ACK} state_t;

  state_t                    state_q;
  logic                      ack_q;
  logic [PTR_W-1:0]          wr_ptr_q;
  logic [PTR_W-1:0]          rd_ptr_q;
  logic [LVL_W-1:0]          level_q;
  logic [DROP_CNT_WIDTH-1:0] drop_q;
  logic [FUNC_WIDTH-1:0]     ch_mem_q   [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]     data_mem_q [FIFO_DEPTH];

  logic [FUNC_WIDTH-1:0] ch_c;
  logic                  match_c;
  logic                  capture_c;
  logic                  full_c;
  logic                  pop_c;
  logic                  push_c;
  logic                  unused_addr_c;

  assign ch_c          = bus.NODE_RX_ADDR[FUNC_WIDTH-1:0];
  assign unused_addr_c = ^bus.NODE_RX_ADDR[ADDR_WIDTH-1:FUNC_WIDTH];
  assign match_c       = bus.NODE_RX_BROADCAST & INTERCEPT_MASK[ch_c] &
                         (bus.MASTER_EN | ~MASTER_ONLY);
  assign capture_c     = (state_q == IDLE) & match_c & bus.NODE_RX_REQ;
  assign full_c        = (level_q == LVL_W'(FIFO_DEPTH));
  assign pop_c         = bus.CAP_POP & (level_q != '0);
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_c        = capture_c & (~full_c | pop_c);

  assign bus.RX_REQ      = match_c ? 1'b0 : bus.NODE_RX_REQ;
  assign bus.NODE_RX_ACK = bus.RX_ACK | ack_q;
  assign bus.CAP_VALID   = (level_q != '0);
  assign bus.CAP_CH      = ch_mem_q[rd_ptr_q];
  assign bus.CAP_DATA    = data_mem_q[rd_ptr_q];
  assign bus.CAP_LEVEL   = level_q;
  assign bus.DROP_CNT    = drop_q;

  always_ff @(posedge CLK_EXT or negedge RESETn_local) begin
    if (!RESETn_local) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        ch_mem_q[i]   <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      // Handshake: hold the auto-ack until the node withdraws its request.
      case (state_q)
        IDLE: begin
          if (capture_c) begin
            ack_q   <= 1'b1;
            state_q <= ACK;
            if (!push_c && (drop_q != {DROP_CNT_WIDTH{1'b1}})) begin
              drop_q <= drop_q + DROP_CNT_WIDTH'(1);
            end
          end
        end
        ACK: begin
          if (!bus.NODE_RX_REQ) begin
            ack_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (push_c) begin
        ch_mem_q[wr_ptr_q]   <= ch_c;
        data_mem_q[wr_ptr_q] <= bus.NODE_RX_DATA;
        wr_ptr_q             <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mbus_bcast_intercept_fifo.sv
// Directed, table-driven bench for the broadcast interceptor (channels 0 and 2
// intercepted, master-only mode, 4-entry FIFO, 8-bit drop counter).
`timescale 1ns/1ps
module tb_mbus_bcast_intercept_fifo;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  mbus_bcast_intercept_fifo_if #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FUNC_WIDTH(4),
    .FIFO_DEPTH(4), .DROP_CNT_WIDTH(8)
  ) bif ();

  mbus_bcast_intercept_fifo #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .FUNC_WIDTH(4),
    .INTERCEPT_MASK(16'h0005), .MASTER_ONLY(1'b1),
    .FIFO_DEPTH(4), .DROP_CNT_WIDTH(8)
  ) dut (
    .CLK_EXT      (clk),
    .RESETn_local (rst_n),
    .bus          (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        bcast;
    logic        me;
    logic [3:0]  ch;
    logic [31:0] data;
    logic        rx_ack;
    logic        exp_rx_req;
    logic        exp_cap;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bcast, input logic me, input logic [3:0] ch,
                       input logic [31:0] data, input logic req);
    bif.NODE_RX_BROADCAST = bcast;
    bif.MASTER_EN         = me;
    bif.NODE_RX_ADDR      = {28'h0, ch};
    bif.NODE_RX_DATA      = data;
    bif.NODE_RX_REQ       = req;
  endtask

  // One complete node transaction: REQ high for one edge, low for one edge.
  task automatic send(input logic bcast, input logic me, input logic [3:0] ch,
                      input logic [31:0] data);
    drive(bcast, me, ch, data, 1'b1);
    tick();
    bif.NODE_RX_REQ = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors = 0;
    checks = 0;
    vecs[0] = '{1'b1, 1'b1, 4'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 4'd0, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 4'd0, 32'h11111111, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 4'd1, 32'h22222222, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 4'd2, 32'h33333333, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b1, 1'b1, 4'd3, 32'h44444444, 1'b0, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 4'd2, 32'h55555555, 1'b1, 1'b1, 1'b0};

    rst_n       = 1'b0;
    bif.RX_ACK  = 1'b0;
    bif.CAP_POP = 1'b0;
    drive(1'b0, 1'b0, 4'd0, 32'h0, 1'b0);
    repeat (2) tick();
    chk("reset_cap_valid", 64'(bif.CAP_VALID), 64'd0);
    chk("reset_level", 64'(bif.CAP_LEVEL), 64'd0);
    chk("reset_drop", 64'(bif.DROP_CNT), 64'd0);
    chk("reset_node_ack", 64'(bif.NODE_RX_ACK), 64'd0);
    chk("reset_cap_ch", 64'(bif.CAP_CH), 64'd0);
    chk("reset_cap_data", 64'(bif.CAP_DATA), 64'd0);
    rst_n = 1'b1;
    tick();

    // Table: match / pass-through / auto-ack per message.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].bcast, vecs[i].me, vecs[i].ch, vecs[i].data, 1'b1);
      bif.RX_ACK = vecs[i].rx_ack;
      #1;
      chk($sformatf("v%0d_rx_req", i), 64'(bif.RX_REQ), 64'(vecs[i].exp_rx_req));
      chk($sformatf("v%0d_ack_pre", i), 64'(bif.NODE_RX_ACK), 64'(vecs[i].rx_ack));
      tick();
      chk($sformatf("v%0d_ack_post", i), 64'(bif.NODE_RX_ACK),
          64'(vecs[i].exp_cap | vecs[i].rx_ack));
      chk($sformatf("v%0d_level", i), 64'(bif.CAP_LEVEL), 64'(vecs[i].exp_cap));
      bif.NODE_RX_REQ = 1'b0;
      bif.RX_ACK      = 1'b0;
      tick();
      chk($sformatf("v%0d_ack_release", i), 64'(bif.NODE_RX_ACK), 64'd0);
      if (vecs[i].exp_cap) begin
        chk($sformatf("v%0d_cap_ch", i), 64'(bif.CAP_CH), 64'(vecs[i].ch));
        chk($sformatf("v%0d_cap_data", i), 64'(bif.CAP_DATA), 64'(vecs[i].data));
        bif.CAP_POP = 1'b1;
        tick();
        bif.CAP_POP = 1'b0;
        chk($sformatf("v%0d_level_pop", i), 64'(bif.CAP_LEVEL), 64'd0);
      end
    end

    // Ordering: channels 2, 1, 0 -> only 2 and 0 queued, in that order.
    send(1'b1, 1'b1, 4'd2, 32'hC2C2C2C2);
    send(1'b1, 1'b1, 4'd1, 32'hC1C1C1C1);
    send(1'b1, 1'b1, 4'd0, 32'hC0C0C0C0);
    chk("order_level", 64'(bif.CAP_LEVEL), 64'd2);
    chk("order_head_ch", 64'(bif.CAP_CH), 64'd2);
    chk("order_head_data", 64'(bif.CAP_DATA), 64'hC2C2C2C2);
    bif.CAP_POP = 1'b1;
    tick();
    chk("order_second_ch", 64'(bif.CAP_CH), 64'd0);
    chk("order_second_data", 64'(bif.CAP_DATA), 64'hC0C0C0C0);
    tick();
    bif.CAP_POP = 1'b0;
    chk("order_empty", 64'(bif.CAP_VALID), 64'd0);
    tick();
    chk("pop_when_empty_ignored", 64'(bif.CAP_LEVEL), 64'd0);

    // Overflow: six pushes into four slots.
    for (int i = 0; i < 6; i++) begin
      send(1'b1, 1'b1, (i % 2 == 0) ? 4'd0 : 4'd2, 32'hA0000000 + 32'(i));
    end
    chk("ovf_level", 64'(bif.CAP_LEVEL), 64'd4);
    chk("ovf_drop", 64'(bif.DROP_CNT), 64'd2);
    chk("ovf_head", 64'(bif.CAP_DATA), 64'hA0000000);

    // Push with concurrent pop at full.
    drive(1'b1, 1'b1, 4'd2, 32'hB0000000, 1'b1);
    bif.CAP_POP = 1'b1;
    tick();
    bif.CAP_POP     = 1'b0;
    bif.NODE_RX_REQ = 1'b0;
    chk("full_pushpop_level", 64'(bif.CAP_LEVEL), 64'd4);
    chk("full_pushpop_drop", 64'(bif.DROP_CNT), 64'd2);
    chk("full_pushpop_head", 64'(bif.CAP_DATA), 64'hA0000001);
    tick();

    // Saturation of the drop counter.
    for (int i = 0; i < 260; i++) send(1'b1, 1'b1, 4'd0, 32'(i));
    chk("drop_saturate", 64'(bif.DROP_CNT), 64'hFF);
    chk("drop_sat_level", 64'(bif.CAP_LEVEL), 64'd4);

    bif.CAP_POP = 1'b1;
    repeat (4) tick();
    bif.CAP_POP = 1'b0;
    chk("drain_level", 64'(bif.CAP_LEVEL), 64'd0);

    // Reset while in ACK with three entries queued.
    send(1'b1, 1'b1, 4'd0, 32'hE0000001);
    send(1'b1, 1'b1, 4'd2, 32'hE0000002);
    drive(1'b1, 1'b1, 4'd0, 32'hE0000003, 1'b1);
    tick();
    chk("ack_state_level", 64'(bif.CAP_LEVEL), 64'd3);
    chk("ack_state_ack", 64'(bif.NODE_RX_ACK), 64'd1);
    repeat (2) tick();
    chk("no_capture_in_ack", 64'(bif.CAP_LEVEL), 64'd3);
    chk("ack_held", 64'(bif.NODE_RX_ACK), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_ack_drop", 64'(bif.NODE_RX_ACK), 64'd0);
    chk("rst_cap_valid", 64'(bif.CAP_VALID), 64'd0);
    chk("rst_level", 64'(bif.CAP_LEVEL), 64'd0);
    chk("rst_drop_cnt", 64'(bif.DROP_CNT), 64'd0);
    bif.NODE_RX_REQ = 1'b0;
    rst_n = 1'b1;
    tick();
    send(1'b1, 1'b1, 4'd0, 32'h12345678);
    chk("post_rst_level", 64'(bif.CAP_LEVEL), 64'd1);
    chk("post_rst_ch", 64'(bif.CAP_CH), 64'd0);
    chk("post_rst_data", 64'(bif.CAP_DATA), 64'h12345678);
    chk("post_rst_ack", 64'(bif.NODE_RX_ACK), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
